// File: rtl/dmem_pkg.sv
// Shared types and constants for the wait-state data memory.
// The optional MMIO cycle counter is enabled with DMEM_MMIO_CYCLE_EN.
package dmem_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned BE_W   = WORD_W / 8;

    localparam logic [31:0] MMIO_CYCLE_ADDR = 32'hFFFF_0000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_storage.sv
// Word array with one byte-enable write port and one asynchronous read port.
// Contents are intentionally not reset.
module dmem_storage
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned IDX_W       = 10
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [WORD_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    input  logic [IDX_W-1:0]  raddr,
    output logic [WORD_W-1:0] rdata
);

    logic [WORD_W-1:0] mem [DEPTH_WORDS];

    // Byte-lane write: only lanes with their enable set are updated
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < BE_W; i++) begin
                if (be[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/wait_state_data_memory.sv
// Single-outstanding data memory responder with a fixed number of wait states.
// Optional feature: DMEM_MMIO_CYCLE_EN exposes a free-running cycle counter
// as a read-only word at MMIO_CYCLE_ADDR.
module wait_state_data_memory
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    output logic [WORD_W-1:0] rsp_rdata,
    output logic              rsp_err
);

    localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int unsigned CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES + 1) : 1;

    state_t            state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [WORD_W-1:0] wdata_q;
    logic [BE_W-1:0]   be_q;

    logic              cur_we;
    logic [31:0]       cur_addr;
    logic [31:0]       cur_off;
    logic [IDX_W-1:0]  cur_idx;
    logic              cur_mmio;
    logic              cur_fault;
    logic              mem_we;
    logic [WORD_W-1:0] mem_rdata;
    logic [WORD_W-1:0] cycle_val;
    logic [WORD_W-1:0] rsp_next;

    // Decode the live request in IDLE so a zero-wait response can be formed
    // at the acceptance edge; elsewhere decode the latched request.
    always_comb begin
        cur_we   = (state == IDLE) ? req_we   : we_q;
        cur_addr = (state == IDLE) ? req_addr : addr_q;
        cur_off  = cur_addr - BASE_ADDR;
        cur_idx  = cur_off[IDX_W+1:2];
`ifdef DMEM_MMIO_CYCLE_EN
        cur_mmio = (cur_addr == MMIO_CYCLE_ADDR);
`else
        cur_mmio = 1'b0;
`endif
        cur_fault = !cur_mmio &&
                    ((cur_addr[1:0] != 2'b00) || ((cur_off >> 2) >= 32'(DEPTH_WORDS)));
    end

    // Stores commit on the edge that ends RESP; faults and MMIO stores are dropped
    always_comb begin
        mem_we = (state == RESP) && we_q && !cur_fault && !cur_mmio;
    end

`ifdef DMEM_MMIO_CYCLE_EN
    logic [31:0] cycle_cnt;

    // Free-running cycle counter, wraps naturally
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cycle_cnt <= '0;
        else       cycle_cnt <= cycle_cnt + 32'd1;
    end

    assign cycle_val = cycle_cnt;
`else
    assign cycle_val = '0;
`endif

    // Response word presented when entering RESP: zero for faults and stores
    always_comb begin
        rsp_next = '0;
        if (!cur_fault && !cur_we) begin
            rsp_next = cur_mmio ? cycle_val : mem_rdata;
        end
    end

    dmem_storage #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_storage (
        .clk   (clk),
        .we    (mem_we),
        .waddr (cur_idx),
        .wdata (wdata_q),
        .be    (be_q),
        .raddr (cur_idx),
        .rdata (mem_rdata)
    );

    // Request FSM with registered handshake and response outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            wait_cnt  <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q      <= req_we;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        be_q      <= req_be;
                        req_ready <= 1'b0;
                        if (WAIT_CYCLES == 0) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_rdata <= rsp_next;
                            rsp_err   <= cur_fault;
                        end else begin
                            state    <= WAIT;
                            wait_cnt <= CNT_W'(WAIT_CYCLES - 1);
                        end
                    end
                end
                WAIT: begin
                    if (wait_cnt == '0) begin
                        state     <= RESP;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= rsp_next;
                        rsp_err   <= cur_fault;
                    end else begin
                        wait_cnt <= wait_cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    state     <= IDLE;
                    req_ready <= 1'b1;
                    rsp_valid <= 1'b0;
                    rsp_rdata <= '0;
                    rsp_err   <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wait_state_data_memory.sv
// Scoreboard bench for wait_state_data_memory. Main instance uses two wait
// states; a second zero-wait instance checks back-to-back spacing.
// Honors DMEM_MMIO_CYCLE_EN when defined.
module tb_wait_state_data_memory;

    localparam int unsigned W     = 2;
    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE  = 32'h0000_0000;
    localparam logic [31:0] MMIO  = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_be;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    logic        v0, we0, rdy0, rv0, re0;
    logic [31:0] a0, wd0, rd0;
    logic [3:0]  be0;

    always #5 clk = ~clk;

    wait_state_data_memory #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk (clk), .reset (reset),
        .req_valid (req_valid), .req_ready (req_ready), .req_we (req_we),
        .req_addr (req_addr), .req_wdata (req_wdata), .req_be (req_be),
        .rsp_valid (rsp_valid), .rsp_rdata (rsp_rdata), .rsp_err (rsp_err)
    );

    wait_state_data_memory #(
        .DEPTH_WORDS (16),
        .WAIT_CYCLES (0),
        .BASE_ADDR   (32'h0000_0000)
    ) dut0 (
        .clk (clk), .reset (reset),
        .req_valid (v0), .req_ready (rdy0), .req_we (we0),
        .req_addr (a0), .req_wdata (wd0), .req_be (be0),
        .rsp_valid (rv0), .rsp_rdata (rd0), .rsp_err (re0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int unsigned cyc;
        bit          mmio;
    } exp_t;

    int          errors = 0;
    int          checks = 0;
    int unsigned cyc = 0;
    int unsigned last_acc = 0;
    logic [31:0] model [DEPTH];
    exp_t        sb [$];
    logic [31:0] mmio_seen [$];
    exp_t        mon_e;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference behaviour: address rules, lane-masked stores, in-order responses
    function automatic exp_t predict(input logic we, input logic [31:0] addr,
                                     input logic [31:0] wdata, input logic [3:0] be);
        exp_t        e;
        logic [31:0] off;
        int unsigned idx;
        e.rdata = '0; e.err = 1'b0; e.cyc = 0; e.mmio = 1'b0;
        off = addr - BASE;
`ifdef DMEM_MMIO_CYCLE_EN
        if (addr == MMIO) begin
            e.mmio = !we;
            return e;
        end
`endif
        if (addr[1:0] != 2'b00 || off / 4 >= DEPTH) begin
            e.err = 1'b1;
            return e;
        end
        idx = off / 4;
        if (we) begin
            for (int l = 0; l < 4; l++)
                if (be[l]) model[idx][8*l +: 8] = wdata[8*l +: 8];
        end else begin
            e.rdata = model[idx];
        end
        return e;
    endfunction

    // Drive one request from a negedge; optionally wiggle inputs during WAIT
    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] be, input bit track, input bit junk);
        int unsigned n = 0;
        exp_t e;
        while (req_ready !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (req_ready !== 1'b1) begin
            checks++; errors++;
            $display("FAIL ready-timeout: got %b expected 1", req_ready);
            return;
        end
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        @(posedge clk);
        #1;
        last_acc = cyc;
        if (track) begin
            e = predict(we, addr, wdata, be);
            e.cyc = cyc + W;
            sb.push_back(e);
        end
        if (junk) begin
            req_valid = 1'b1; req_we = 1'b1; req_addr = $urandom & 32'hFC;
            req_wdata = $urandom; req_be = 4'hF;
            @(negedge clk);
            @(negedge clk);
            req_valid = 1'b0;
        end else begin
            req_valid = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic drain();
        int unsigned n = 0;
        while (sb.size() > 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("drain-pending", sb.size(), 0);
    endtask

    // Monitor: every response pops the scoreboard; idle outputs must be zero
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected-rsp: got rsp_valid=1 expected no response");
            end else begin
                mon_e = sb.pop_front();
                chk("rsp-cycle", cyc, mon_e.cyc);
                chk("rsp-err", {31'd0, rsp_err}, {31'd0, mon_e.err});
                chk("rsp-ready-low", {31'd0, req_ready}, 32'd0);
                if (mon_e.mmio) mmio_seen.push_back(rsp_rdata);
                else chk("rsp-rdata", rsp_rdata, mon_e.rdata);
            end
        end else begin
            chk("idle-outputs", {rsp_rdata[30:0], rsp_err}, 32'd0);
        end
    end

    initial begin
        logic [31:0] m0 [6];
        int unsigned acc_n, rsp_n, acc0, n, r;
        bit          prev_rv;
        logic [31:0] addr;

        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
        v0 = 1'b0; we0 = 1'b0; a0 = '0; wd0 = '0; be0 = '0;
        repeat (3) @(negedge clk);
        chk("reset-ready", {31'd0, req_ready}, 32'd1);
        chk("reset-valid", {31'd0, rsp_valid}, 32'd0);
        chk("reset-rdata", rsp_rdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < DEPTH; i++) issue(1'b1, BASE + 4 * i, $urandom, 4'hF, 1'b1, 1'b0);

        issue(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
        issue(1'b1, 32'h10, 32'h1122_3344, 4'b0101, 1'b1, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
        issue(1'b0, 32'h12, 32'h0, 4'h0, 1'b1, 1'b0);
        issue(1'b0, BASE + 4 * DEPTH, 32'h0, 4'h0, 1'b1, 1'b0);
        issue(1'b1, 32'h14, 32'h5555_5555, 4'h0, 1'b1, 1'b0);
        issue(1'b0, 32'h10, 32'h0, 4'h0, 1'b1, 1'b0);
        drain();
        chk("partial-store-model", model[4], 32'hDE22_BE44);

        // Abort a store in WAIT with an asynchronous reset
        issue(1'b1, 32'h20, 32'hCAFE_F00D, 4'hF, 1'b0, 1'b0);
        #1 reset = 1'b1;
        #1;
        chk("abort-valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort-ready", {31'd0, req_ready}, 32'd1);
        chk("abort-rdata", rsp_rdata, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(1'b0, 32'h20, 32'h0, 4'h0, 1'b1, 1'b0);
        drain();

        for (int k = 0; k < 200; k++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       addr = BASE + 4 * $urandom_range(0, DEPTH - 1);
            else if (r == 7) addr = BASE + 4 * $urandom_range(0, DEPTH - 1) + $urandom_range(1, 3);
            else if (r == 8) addr = BASE + 4 * DEPTH + 4 * $urandom_range(0, 15);
            else             addr = ($urandom_range(0, 1) == 0) ? BASE - 4 : MMIO;
            issue($urandom_range(0, 1), addr, $urandom, $urandom_range(0, 15), 1'b1,
                  $urandom_range(0, 3) == 0);
        end
        drain();

        // Two counter reads accepted exactly ten cycles apart
        mmio_seen.delete();
        issue(1'b0, MMIO, 32'h0, 4'h0, 1'b1, 1'b0);
        acc0 = last_acc;
        n = 0;
        while (cyc != acc0 + 9 && n < 50) begin
            @(negedge clk);
            n++;
        end
        issue(1'b0, MMIO, 32'h0, 4'h0, 1'b1, 1'b0);
        chk("mmio-accept-gap", last_acc - acc0, 32'd10);
        drain();
`ifdef DMEM_MMIO_CYCLE_EN
        chk("mmio-reads", mmio_seen.size(), 32'd2);
        if (mmio_seen.size() == 2) chk("mmio-delta", mmio_seen[1] - mmio_seen[0], 32'd10);
`endif

        // Zero-wait instance: fill six words then stream loads with valid held high
        for (int i = 0; i < 6; i++) begin
            m0[i] = $urandom;
            n = 0;
            while (rdy0 !== 1'b1 && n < 10) begin
                @(negedge clk);
                n++;
            end
            v0 = 1'b1; we0 = 1'b1; a0 = 4 * i; wd0 = m0[i]; be0 = 4'hF;
            @(negedge clk);
            v0 = 1'b0;
            @(negedge clk);
        end
        v0 = 1'b1; we0 = 1'b0; a0 = 32'h0;
        acc_n = 0; rsp_n = 0; acc0 = 0; prev_rv = 1'b0;
        for (int t = 0; t < 40 && rsp_n < 6; t++) begin
            if (rv0 === 1'b1) begin
                chk("w0-ready-in-resp", {31'd0, rdy0}, 32'd0);
                chk("w0-err", {31'd0, re0}, 32'd0);
                chk("w0-rdata", rd0, m0[rsp_n]);
                chk("w0-pulse", {31'd0, prev_rv}, 32'd0);
                rsp_n++;
                a0 = 4 * acc_n;
                if (acc_n >= 6) v0 = 1'b0;
            end
            if (rdy0 === 1'b1 && v0 === 1'b1) begin
                if (acc_n > 0) chk("w0-accept-spacing", cyc - acc0, 32'd2);
                acc0 = cyc;
                acc_n++;
            end
            prev_rv = (rv0 === 1'b1);
            @(negedge clk);
        end
        v0 = 1'b0;
        chk("w0-load-count", rsp_n, 32'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
